// File: rtl/fabscalar_pkg.sv
// Shared front-end sizing constants used by the decode-to-instruction-buffer path.
// Also holds the lane-count constants and the thermometer-code helper.
package fabscalar_pkg;

  localparam int SIZE_SPECIAL_REG = 32;
  localparam int LDST_TYPES_LOG   = 2;
  localparam int INST_TYPES_LOG   = 2;
  localparam int SIZE_IMMEDIATE   = 16;
  localparam int SIZE_RMT_LOG     = 5;
  localparam int SIZE_OPCODE_I    = 8;
  localparam int SIZE_PC          = 32;
  localparam int SIZE_CTI_LOG     = 2;
  localparam int FETCH_BANDWIDTH  = 4;

  localparam int DECODED_PKT_W = 2*SIZE_SPECIAL_REG + 3 + LDST_TYPES_LOG + INST_TYPES_LOG +
                                 SIZE_IMMEDIATE + 1 + 3*SIZE_RMT_LOG + 3 + SIZE_OPCODE_I +
                                 2*SIZE_PC + SIZE_CTI_LOG + 1;

  localparam int LANES      = 2*FETCH_BANDWIDTH;
  localparam int LANE_IDX_W = $clog2(LANES);
  localparam int CNT_W      = 4;

  // Counts of 8 or more saturate to all lanes set.
  function automatic logic [LANES-1:0] thermometer(input logic [CNT_W-1:0] n);
    logic [LANES:0] one;
    logic [LANES:0] t;
    one = 1;
    t   = (one << n) - one;
    return t[LANES-1:0];
  endfunction

endpackage

// File: rtl/lane_compactor.sv
// Packs the valid lanes of a sparse decode bundle into contiguous low lanes.
// Each valid input lane is steered to the output lane given by its prefix popcount.
module lane_compactor
  import fabscalar_pkg::*;
#(
  parameter int PKT_W = DECODED_PKT_W
) (
  input  logic [LANES-1:0]            i_vec,
  input  logic [LANES-1:0][PKT_W-1:0] i_pkts,
  output logic [LANES-1:0][PKT_W-1:0] o_pkts,
  output logic [CNT_W-1:0]            o_count
);

  logic [CNT_W-1:0] w_acc;

  // w_acc holds the number of valid lanes below lane i when lane i is visited.
  always_comb begin
    w_acc  = '0;
    o_pkts = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i_vec[i]) begin
        o_pkts[w_acc[LANE_IDX_W-1:0]] = i_pkts[i];
        w_acc = w_acc + 1'b1;
      end
    end
    o_count = w_acc;
  end

endmodule

// File: rtl/decode_bundle_packer.sv
// Latches a compacted decode bundle for the instruction buffer's write port,
// holding it under fetch stall and pushing that backpressure back to Decode.
module decode_bundle_packer
  import fabscalar_pkg::*;
#(
  parameter int PKT_W = DECODED_PKT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             decodeValid_i,
  input  logic [LANES-1:0] decodedVector_i,
  input  logic [PKT_W-1:0] decodedPacket0_i,
  input  logic [PKT_W-1:0] decodedPacket1_i,
  input  logic [PKT_W-1:0] decodedPacket2_i,
  input  logic [PKT_W-1:0] decodedPacket3_i,
  input  logic [PKT_W-1:0] decodedPacket4_i,
  input  logic [PKT_W-1:0] decodedPacket5_i,
  input  logic [PKT_W-1:0] decodedPacket6_i,
  input  logic [PKT_W-1:0] decodedPacket7_i,
  input  logic             stallFetch_i,
  output logic             stallDecode_o,
  output logic             decodeReady_o,
  output logic [LANES-1:0] decodedVector_o,
  output logic [PKT_W-1:0] decodedPacket0_o,
  output logic [PKT_W-1:0] decodedPacket1_o,
  output logic [PKT_W-1:0] decodedPacket2_o,
  output logic [PKT_W-1:0] decodedPacket3_o,
  output logic [PKT_W-1:0] decodedPacket4_o,
  output logic [PKT_W-1:0] decodedPacket5_o,
  output logic [PKT_W-1:0] decodedPacket6_o,
  output logic [PKT_W-1:0] decodedPacket7_o,
  output logic [CNT_W-1:0] bundleCount_o
);

  logic                            r_valid;
  logic [CNT_W-1:0]                r_cnt;
  logic [LANES-1:0][PKT_W-1:0]     r_pkt;

  logic [LANES-1:0][PKT_W-1:0]     w_inPkts;
  logic [LANES-1:0][PKT_W-1:0]     w_compact;
  logic [CNT_W-1:0]                w_count;
  logic                            w_load;

  assign w_inPkts = {decodedPacket7_i, decodedPacket6_i, decodedPacket5_i, decodedPacket4_i,
                     decodedPacket3_i, decodedPacket2_i, decodedPacket1_i, decodedPacket0_i};

  lane_compactor #(.PKT_W(PKT_W)) u_compactor (
    .i_vec   (decodedVector_i),
    .i_pkts  (w_inPkts),
    .o_pkts  (w_compact),
    .o_count (w_count)
  );

  assign stallDecode_o = r_valid & stallFetch_i;
  assign w_load        = ~stallDecode_o & ~flush_i;

  // An empty bundle is dropped rather than presented, so a zero count clears the register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_pkt   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_pkt   <= '0;
    end else if (w_load) begin
      if (decodeValid_i && (w_count != '0)) begin
        r_valid <= 1'b1;
        r_cnt   <= w_count;
        r_pkt   <= w_compact;
      end else begin
        r_valid <= 1'b0;
        r_cnt   <= '0;
        r_pkt   <= '0;
      end
    end
  end

  assign decodeReady_o    = r_valid;
  assign decodedVector_o  = thermometer(r_cnt);
  assign bundleCount_o    = r_cnt;
  assign decodedPacket0_o = r_pkt[0];
  assign decodedPacket1_o = r_pkt[1];
  assign decodedPacket2_o = r_pkt[2];
  assign decodedPacket3_o = r_pkt[3];
  assign decodedPacket4_o = r_pkt[4];
  assign decodedPacket5_o = r_pkt[5];
  assign decodedPacket6_o = r_pkt[6];
  assign decodedPacket7_o = r_pkt[7];

endmodule

// File: tb/tb_decode_bundle_packer.sv
// Self-checking bench for decode_bundle_packer: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the bundle register.
module tb_decode_bundle_packer;
  import fabscalar_pkg::*;

  localparam int W = DECODED_PKT_W;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush_i;
  logic         decodeValid_i;
  logic [7:0]   decodedVector_i;
  logic [W-1:0] inPkt [8];
  logic         stallFetch_i;
  logic         stallDecode_o;
  logic         decodeReady_o;
  logic [7:0]   decodedVector_o;
  logic [W-1:0] outPkt [8];
  logic [3:0]   bundleCount_o;

  int compared   = 0;
  int mismatched = 0;

  logic         mValid;
  int           mCnt;
  logic [W-1:0] mPkt [8];
  logic [W-1:0] savedA [8];

  always #5 clk = ~clk;

  decode_bundle_packer dut (
    .clk              (clk),
    .reset            (reset),
    .flush_i          (flush_i),
    .decodeValid_i    (decodeValid_i),
    .decodedVector_i  (decodedVector_i),
    .decodedPacket0_i (inPkt[0]),
    .decodedPacket1_i (inPkt[1]),
    .decodedPacket2_i (inPkt[2]),
    .decodedPacket3_i (inPkt[3]),
    .decodedPacket4_i (inPkt[4]),
    .decodedPacket5_i (inPkt[5]),
    .decodedPacket6_i (inPkt[6]),
    .decodedPacket7_i (inPkt[7]),
    .stallFetch_i     (stallFetch_i),
    .stallDecode_o    (stallDecode_o),
    .decodeReady_o    (decodeReady_o),
    .decodedVector_o  (decodedVector_o),
    .decodedPacket0_o (outPkt[0]),
    .decodedPacket1_o (outPkt[1]),
    .decodedPacket2_o (outPkt[2]),
    .decodedPacket3_o (outPkt[3]),
    .decodedPacket4_o (outPkt[4]),
    .decodedPacket5_o (outPkt[5]),
    .decodedPacket6_o (outPkt[6]),
    .decodedPacket7_o (outPkt[7]),
    .bundleCount_o    (bundleCount_o)
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [W-1:0] randPkt();
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) r[b] = 1'($urandom_range(1, 0));
    return r;
  endfunction

  task automatic newPackets();
    for (int i = 0; i < 8; i++) inPkt[i] = randPkt();
  endtask

  task automatic modelClear();
    mValid = 1'b0;
    mCnt   = 0;
    for (int k = 0; k < 8; k++) mPkt[k] = '0;
  endtask

  // Reference behaviour of one clock edge, evaluated with the pre-edge state.
  task automatic modelClock();
    logic [W-1:0] q[$];
    logic stalled;
    stalled = mValid && stallFetch_i;
    if (flush_i) modelClear();
    else if (!stalled) begin
      for (int i = 0; i < 8; i++)
        if (decodedVector_i[i]) q.push_back(inPkt[i]);
      if (decodeValid_i && q.size() > 0) begin
        mValid = 1'b1;
        mCnt   = q.size();
        for (int k = 0; k < 8; k++) mPkt[k] = (k < q.size()) ? q[k] : '0;
      end else modelClear();
    end
  endtask

  task automatic checkAll();
    logic [7:0] expVec;
    expVec = '0;
    for (int k = 0; k < mCnt; k++) expVec[k] = 1'b1;
    checkOutput("decodeReady", 256'(decodeReady_o), 256'(mValid));
    checkOutput("decodedVector", 256'(decodedVector_o), 256'(expVec));
    checkOutput("bundleCount", 256'(bundleCount_o), 256'(mCnt));
    checkOutput("stallDecode", 256'(stallDecode_o), 256'(mValid && stallFetch_i && !reset));
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("pkt%0d", k), 256'(outPkt[k]), 256'(mPkt[k]));
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] vec,
                               input logic stall, input logic flush);
    @(negedge clk);
    decodeValid_i   = valid;
    decodedVector_i = vec;
    stallFetch_i    = stall;
    flush_i         = flush;
    #1;
    checkOutput("stallDecodeComb", 256'(stallDecode_o), 256'(mValid && stall));
    @(posedge clk);
    modelClock();
    #1;
    checkAll();
  endtask

  initial begin
    reset = 1'b1;
    flush_i = 1'b0;
    decodeValid_i = 1'b0;
    decodedVector_i = '0;
    stallFetch_i = 1'b0;
    for (int i = 0; i < 8; i++) inPkt[i] = '0;
    modelClear();
    #2;
    checkAll();
    @(negedge clk);
    reset = 1'b0;

    // Sparse compaction
    newPackets();
    applyStimulus(1'b1, 8'b1010_0101, 1'b0, 1'b0);
    checkOutput("sparseVec", 256'(decodedVector_o), 256'(8'h0F));
    checkOutput("sparseCnt", 256'(bundleCount_o), 256'(4));
    checkOutput("sparseLane0", 256'(outPkt[0]), 256'(inPkt[0]));
    checkOutput("sparseLane1", 256'(outPkt[1]), 256'(inPkt[2]));
    checkOutput("sparseLane2", 256'(outPkt[2]), 256'(inPkt[5]));
    checkOutput("sparseLane3", 256'(outPkt[3]), 256'(inPkt[7]));
    checkOutput("sparseLane4", 256'(outPkt[4]), 256'(0));

    // Full and empty bundles
    newPackets();
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    checkOutput("fullVec", 256'(decodedVector_o), 256'(8'hFF));
    checkOutput("fullCnt", 256'(bundleCount_o), 256'(8));
    checkOutput("fullLane7", 256'(outPkt[7]), 256'(inPkt[7]));
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("emptyReady", 256'(decodeReady_o), 256'(0));

    // Backpressure: A held for three stall cycles while B is offered
    newPackets();
    applyStimulus(1'b1, 8'b0110_1001, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) savedA[k] = outPkt[k];
    newPackets();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 8'b1100_0011, 1'b1, 1'b0);
      checkOutput("holdStall", 256'(stallDecode_o), 256'(1));
      checkOutput("holdLane1", 256'(outPkt[1]), 256'(savedA[1]));
    end
    applyStimulus(1'b1, 8'b1100_0011, 1'b0, 1'b0);
    checkOutput("releaseLane2", 256'(outPkt[2]), 256'(inPkt[6]));

    // Flush during stall drops both the held bundle and the offered input
    newPackets();
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    newPackets();
    applyStimulus(1'b1, 8'hF0, 1'b1, 1'b1);
    checkOutput("flushReady", 256'(decodeReady_o), 256'(0));
    checkOutput("flushVec", 256'(decodedVector_o), 256'(0));
    applyStimulus(1'b0, 8'hF0, 1'b0, 1'b0);
    checkOutput("flushNoGhost", 256'(decodeReady_o), 256'(0));

    // Asynchronous reset while a bundle is held under stall
    newPackets();
    applyStimulus(1'b1, 8'h81, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h81, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    modelClear();
    checkAll();
    checkOutput("resetReady", 256'(decodeReady_o), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    newPackets();
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    checkOutput("postResetLane1", 256'(outPkt[1]), 256'(inPkt[4]));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      newPackets();
      applyStimulus(1'($urandom_range(3, 0) != 0), 8'($urandom()),
                    1'($urandom_range(9, 0) < 3), 1'($urandom_range(19, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decode_bundle_packer.md
# decode_bundle_packer

Producer-side stage that drives the instruction buffer's write interface. Latches up to eight decoded packets per cycle from Decode and compacts the sparse valid lanes into contiguous low lanes, because the buffer writes lane N at tail+N. Holds the bundle while the buffer raises its fetch stall, and propagates that backpressure to Decode. Sits between Decode and the instruction buffer.

## Interface
- PKT_W, default `DECODED_PKT_W` from package: width of one decoded packet.
- LANES, fixed 8 (2*`FETCH_BANDWIDTH`): packet lanes per bundle.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- flush_i  in  1  control mispredict; discards the held bundle and the same-cycle input.
- decodeValid_i  in  1  Decode presents a bundle this cycle.
- decodedVector_i  in  8  per-lane valid; may be sparse, e.g. 8'b1010_0101.
- decodedPacket0_i..decodedPacket7_i  in  PKT_W each  raw decoded packets.
- stallFetch_i  in  1  instruction buffer cannot accept a bundle.
- stallDecode_o  out  1  backpressure to Decode; when 1, the input is not consumed.
- decodeReady_o  out  1  held bundle valid; drives the buffer's decodeReady_i.
- decodedVector_o  out  8  thermometer code (2^n - 1) for n held packets.
- decodedPacket0_o..decodedPacket7_o  out  PKT_W each  compacted packets; lanes >= n are zero.
- bundleCount_o  out  4  n, the number of packets held (0..8).

## Operation
- State: valid_q, cnt_q[3:0], pkt_q[0..7].
- Compaction: output lane k takes the input lane holding the k-th set bit of decodedVector_i, in ascending lane order. n = popcount(decodedVector_i).
- Consumption: the buffer takes the bundle in any cycle where valid_q=1 and stallFetch_i=0.
- stallDecode_o = valid_q & stallFetch_i. This output is combinational.
- Load enable: load = ~stallDecode_o & ~flush_i.
  - On load with decodeValid_i=1 and n>0: valid_q←1, cnt_q←n, pkt_q←compacted lanes, with unused lanes zeroed.
  - On load with decodeValid_i=0 or n=0: valid_q←0, cnt_q←0, pkt_q←0. An empty bundle is never presented.
- Hold: when stallDecode_o=1, all state is unchanged and the input is ignored. Decode must hold its outputs.
- Flush: flush_i=1 forces valid_q←0, cnt_q←0, pkt_q←0 regardless of stall or input. stallDecode_o still follows the current state during the flush cycle.
- Outputs: decodeReady_o=valid_q; decodedVector_o=(1<<cnt_q)-1 (8'hFF when cnt_q=8); bundleCount_o=cnt_q.
- Invariant: decodedVector_o is always a thermometer code, and it is zero when decodeReady_o=0.

## Timing
- Latency: one cycle from input acceptance to decodeReady_o.
- Throughput: one bundle per cycle when stallFetch_i=0.
- Reset: asynchronous assertion clears all state immediately. All outputs read 0, including stallDecode_o. Release is synchronous to the next posedge.
- Stall, then release: the held bundle stays stable for every stall cycle. In the first cycle with stallFetch_i=0 it is consumed and the next input loads at that same edge, with no bubble.
- Simultaneous flush and stallFetch_i: flush wins, and the register empties at the edge.
- Reset asserted mid-stall: the held bundle is lost and the block resumes empty.
- Popcount width: 4 bits. The all-ones vector gives n=8 with no overflow.

## Structure
- Shared package (fabscalar_pkg):
  - `DECODED_PKT_W` = 2*`SIZE_SPECIAL_REG`+3+`LDST_TYPES_LOG`+`INST_TYPES_LOG`+`SIZE_IMMEDIATE`+1+3*`SIZE_RMT_LOG`+3+`SIZE_OPCODE_I`+2*`SIZE_PC`+`SIZE_CTI_LOG`+1
  - `FETCH_BANDWIDTH`
  - lane-count constant
- Sub-module lane_compactor: purely combinational. Takes an 8-bit vector and 8 packets, and produces compacted packets plus the count via a prefix-popcount select. It is instantiated once.
- Top level: pipeline register, stall/flush control, output encoding.

## Test plan
- Sparse compaction: vector 8'b1010_0101 with packets P0..P7, no stall → next cycle decodeReady_o=1, decodedVector_o=8'h0F, lanes 0..3 = P0,P2,P5,P7, lanes 4..7 = 0, bundleCount_o=4.
- Full bundle: vector 8'hFF → decodedVector_o=8'hFF, bundleCount_o=8, packets in order. Empty bundle: vector 8'h00 with decodeValid_i=1 → decodeReady_o=0.
- Backpressure: load bundle A, hold stallFetch_i=1 for 3 cycles while Decode presents B → A stable and stallDecode_o=1 throughout. On release, A is consumed and B appears on the next cycle.
- Flush during stall: bundle held, stallFetch_i=1 and flush_i=1 in the same cycle → next cycle decodeReady_o=0 and decodedVector_o=0. The input B offered during the flush cycle never appears.
- Asynchronous reset mid-operation: assert reset between clock edges with a bundle held → all outputs read 0 before the next edge. After release, the first valid input loads normally.
